// File: rtl/fb_scanout.sv
// 256x256x9 frame buffer with independent write port and a VGA-style raster scanout.
// Define FB_BORDER_EN to draw a white 1-pixel ring around the image window.
module fb_scanout #(
  parameter int CLK_DIV = 2,
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int IMG_X0  = 192,
  parameter int IMG_Y0  = 112
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       WE,
  input  logic [7:0] WX,
  input  logic [7:0] WY,
  input  logic [2:0] WR,
  input  logic [2:0] WG,
  input  logic [2:0] WB,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       DE,
  output logic [2:0] VR,
  output logic [2:0] VG,
  output logic [2:0] VB,
  output logic       FRAME_START
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    RG_ACTIVE = 2'd0,
    RG_FP     = 2'd1,
    RG_SYNC   = 2'd2,
    RG_BP     = 2'd3
  } region_e;

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  region_e       hst_q, hst_d, vst_q, vst_d;
  logic          tick_s, line_end_s;

  logic [8:0]  mem_q [65536];
  logic [8:0]  rdata_q;
  logic [15:0] raddr_s;
  int          hc_s, vc_s;
  logic        win_s, bord_s;

  logic s1_vld_q, s1_hs_q, s1_vs_q, s1_de_q, s1_win_q, s1_bord_q, s1_first_q;
  logic       hsync_q, vsync_q, de_q, fs_q;
  logic [8:0] rgb_q, rgb_d;

  // Pixel divider, raster counters and region state registers
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      hst_q  <= RG_ACTIVE;
      vst_q  <= RG_ACTIVE;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      hst_q  <= hst_d;
      vst_q  <= vst_d;
    end
  end

  // Next-state: counters wrap, region FSMs step at each boundary count
  always_comb begin
    tick_s     = (div_q == DW'(CLK_DIV - 1));
    line_end_s = tick_s && (hcnt_q == HW'(H_TOT - 1));
    div_d      = tick_s ? '0 : div_q + DW'(1);
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    hst_d      = hst_q;
    vst_d      = vst_q;
    if (tick_s) begin
      hcnt_d = line_end_s ? '0 : hcnt_q + HW'(1);
      case (hst_q)
        RG_ACTIVE: hst_d = (hcnt_q == HW'(H_ACT - 1))                 ? RG_FP     : RG_ACTIVE;
        RG_FP:     hst_d = (hcnt_q == HW'(H_ACT + H_FP - 1))          ? RG_SYNC   : RG_FP;
        RG_SYNC:   hst_d = (hcnt_q == HW'(H_ACT + H_FP + H_SYNC - 1)) ? RG_BP     : RG_SYNC;
        RG_BP:     hst_d = (hcnt_q == HW'(H_TOT - 1))                 ? RG_ACTIVE : RG_BP;
        default:   hst_d = RG_ACTIVE;
      endcase
    end else begin
      hcnt_d = hcnt_q;
    end
    if (line_end_s) begin
      vcnt_d = (vcnt_q == VW'(V_TOT - 1)) ? '0 : vcnt_q + VW'(1);
      case (vst_q)
        RG_ACTIVE: vst_d = (vcnt_q == VW'(V_ACT - 1))                 ? RG_FP     : RG_ACTIVE;
        RG_FP:     vst_d = (vcnt_q == VW'(V_ACT + V_FP - 1))          ? RG_SYNC   : RG_FP;
        RG_SYNC:   vst_d = (vcnt_q == VW'(V_ACT + V_FP + V_SYNC - 1)) ? RG_BP     : RG_SYNC;
        RG_BP:     vst_d = (vcnt_q == VW'(V_TOT - 1))                 ? RG_ACTIVE : RG_BP;
        default:   vst_d = RG_ACTIVE;
      endcase
    end else begin
      vcnt_d = vcnt_q;
    end
  end

  // Stage 0: window test and buffer address from the current raster position
  always_comb begin
    hc_s    = int'(hcnt_q);
    vc_s    = int'(vcnt_q);
    win_s   = (hc_s >= IMG_X0) && (hc_s < IMG_X0 + 256) &&
              (vc_s >= IMG_Y0) && (vc_s < IMG_Y0 + 256);
    raddr_s = {8'(vcnt_q - VW'(IMG_Y0)), 8'(hcnt_q - HW'(IMG_X0))};
`ifdef FB_BORDER_EN
    bord_s  = !win_s && (hc_s >= IMG_X0 - 1) && (hc_s <= IMG_X0 + 256) &&
              (vc_s >= IMG_Y0 - 1) && (vc_s <= IMG_Y0 + 256);
`else
    bord_s  = 1'b0;
`endif
  end

  // Frame buffer: read-first, so a same-CLK write is seen only next frame
  always_ff @(posedge CLK) begin
    if (WE) begin
      mem_q[{WY, WX}] <= {WR, WG, WB};
    end
    if (tick_s) begin
      rdata_q <= mem_q[raddr_s];
    end
  end

  // Stage 1: timing flags travel alongside the RAM read
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      s1_vld_q   <= 1'b0;
      s1_hs_q    <= 1'b1;
      s1_vs_q    <= 1'b1;
      s1_de_q    <= 1'b0;
      s1_win_q   <= 1'b0;
      s1_bord_q  <= 1'b0;
      s1_first_q <= 1'b0;
    end else if (tick_s) begin
      s1_vld_q   <= 1'b1;
      s1_hs_q    <= (hst_q != RG_SYNC);
      s1_vs_q    <= (vst_q != RG_SYNC);
      s1_de_q    <= (hst_q == RG_ACTIVE) && (vst_q == RG_ACTIVE);
      s1_win_q   <= win_s;
      s1_bord_q  <= bord_s;
      s1_first_q <= (hcnt_q == '0) && (vcnt_q == '0);
    end
  end

  // Stage 2 colour select: blank outside the active area
  always_comb begin
    rgb_d = 9'h000;
    if (!(s1_vld_q && s1_de_q)) begin
      rgb_d = 9'h000;
    end else if (s1_win_q) begin
      rgb_d = rdata_q;
    end else if (s1_bord_q) begin
      rgb_d = 9'h1FF;
    end else begin
      rgb_d = 9'h000;
    end
  end

  // Stage 2 output registers; FRAME_START lasts one CLK even when CLK_DIV > 1
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      rgb_q   <= 9'h000;
      fs_q    <= 1'b0;
    end else begin
      fs_q <= tick_s && s1_vld_q && s1_first_q;
      if (tick_s) begin
        hsync_q <= s1_hs_q;
        vsync_q <= s1_vs_q;
        de_q    <= s1_vld_q && s1_de_q;
        rgb_q   <= rgb_d;
      end
    end
  end

  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign DE          = de_q;
  assign VR          = rgb_q[8:6];
  assign VG          = rgb_q[5:3];
  assign VB          = rgb_q[2:0];
  assign FRAME_START = fs_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: a CLK_DIV=1 instance with a shortened vertical
// timing for frame-level checks, plus a default CLK_DIV=2 instance for pixel hold.
module tb_fb_scanout;

  logic       CLK = 1'b0;
  logic       NRST;
  logic       WE;
  logic [7:0] WX, WY;
  logic [2:0] WR, WG, WB;

  logic       hs1, vs1, de1, fs1;
  logic [2:0] r1, g1, b1;
  logic       hs2, vs2, de2, fs2;
  logic [2:0] r2, g2, b2;

  int n_chk  = 0;
  int n_fail = 0;
  int ncyc   = 0;

`ifdef FB_BORDER_EN
  localparam logic [8:0] BORD = 9'h1FF;
`else
  localparam logic [8:0] BORD = 9'h000;
`endif

  always #5 CLK = ~CLK;

  fb_scanout #(
    .CLK_DIV(1), .V_ACT(20), .V_FP(2), .V_SYNC(2), .V_BP(2), .IMG_Y0(4)
  ) u_dut (
    .CLK(CLK), .NRST(NRST), .WE(WE), .WX(WX), .WY(WY), .WR(WR), .WG(WG), .WB(WB),
    .HSYNC(hs1), .VSYNC(vs1), .DE(de1), .VR(r1), .VG(g1), .VB(b1), .FRAME_START(fs1)
  );

  fb_scanout u_dut2 (
    .CLK(CLK), .NRST(NRST), .WE(WE), .WX(WX), .WY(WY), .WR(WR), .WG(WG), .WB(WB),
    .HSYNC(hs2), .VSYNC(vs2), .DE(de2), .VR(r2), .VG(g2), .VB(b2), .FRAME_START(fs2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, ncyc);
    end
  endtask

  task automatic go_to(input int c);
    while (ncyc < c) begin
      @(negedge CLK);
      ncyc++;
    end
  endtask

  // pixel (h,v) of the CLK_DIV=1 instance is on the outputs 2 CLK after its read
  task automatic px1(input string tag, input int h, input int v, input logic [8:0] exp);
    go_to(2 + v * 800 + h);
    check_eq(tag, {23'd0, r1, g1, b1}, {23'd0, exp});
  endtask

  task automatic wr(input logic [7:0] y, input logic [7:0] x, input logic [8:0] rgb);
    WE = 1'b1; WY = y; WX = x; {WR, WG, WB} = rgb;
    go_to(ncyc + 1);
    WE = 1'b0;
  endtask

  initial begin
    NRST = 1'b0; WE = 1'b0; WX = 8'd0; WY = 8'd0; WR = 3'd0; WG = 3'd0; WB = 3'd0;
    repeat (3) @(negedge CLK);
    check_eq("rst_hsync", 32'(hs1), 32'd1);
    check_eq("rst_vsync", 32'(vs1), 32'd1);
    check_eq("rst_de", 32'(de1), 32'd0);
    check_eq("rst_rgb", {23'd0, r1, g1, b1}, 32'd0);
    check_eq("rst_fs", 32'(fs1), 32'd0);
    check_eq("rst_de2", 32'(de2), 32'd0);

    NRST = 1'b1; ncyc = 0;
    go_to(1); check_eq("fs_early", 32'(fs1), 32'd0);
    go_to(2); check_eq("fs_first", 32'(fs1), 32'd1);
              check_eq("de_first", 32'(de1), 32'd1);
    go_to(3); check_eq("fs_pulse", 32'(fs1), 32'd0);
    go_to(4); check_eq("fs2_first", 32'(fs2), 32'd1);
              check_eq("de2_first", 32'(de2), 32'd1);
    go_to(5); check_eq("fs2_pulse", 32'(fs2), 32'd0);
              check_eq("de2_hold", 32'(de2), 32'd1);

    go_to(10);
    wr(8'd0, 8'd0, 9'o111);
    wr(8'd5, 8'd255, 9'o005);

    go_to(641);  check_eq("de_h639", 32'(de1), 32'd1);
    go_to(642);  check_eq("de_h640", 32'(de1), 32'd0);
    go_to(657);  check_eq("hs_h655", 32'(hs1), 32'd1);
    go_to(658);  check_eq("hs_h656", 32'(hs1), 32'd0);
    go_to(753);  check_eq("hs_h751", 32'(hs1), 32'd0);
    go_to(754);  check_eq("hs_h752", 32'(hs1), 32'd1);
    go_to(1283); check_eq("de2_h639", 32'(de2), 32'd1);
    go_to(1284); check_eq("de2_h640", 32'(de2), 32'd0);
    go_to(1315); check_eq("hs2_h655", 32'(hs2), 32'd1);
    go_to(1316); check_eq("hs2_h656a", 32'(hs2), 32'd0);
    go_to(1317); check_eq("hs2_h656b", 32'(hs2), 32'd0);
    go_to(1457); check_eq("hs_l1_h655", 32'(hs1), 32'd1);
    go_to(1458); check_eq("hs_l1_h656", 32'(hs1), 32'd0);

    px1("border_300_3", 300, 3, BORD);
    check_eq("de_300_3", 32'(de1), 32'd1);

    // collision: write lands on the same CLK the scanout reads (192,4)
    go_to(3392);
    wr(8'd0, 8'd0, 9'o333);
    px1("border_191_4", 191, 4, BORD);
    px1("coll_old", 192, 4, 9'o111);
    px1("px_447_9", 447, 9, 9'o005);
    px1("border_448_9", 448, 9, BORD);

    go_to(15202); check_eq("de_v19", 32'(de1), 32'd1);
    go_to(16002); check_eq("de_v20", 32'(de1), 32'd0);
    go_to(17601); check_eq("vs_v21", 32'(vs1), 32'd1);
    go_to(17602); check_eq("vs_v22", 32'(vs1), 32'd0);
    go_to(19201); check_eq("vs_v23", 32'(vs1), 32'd0);
    go_to(19202); check_eq("vs_v24", 32'(vs1), 32'd1);
    go_to(20801); check_eq("fs_f2_early", 32'(fs1), 32'd0);
    go_to(20802); check_eq("fs_f2", 32'(fs1), 32'd1);

    go_to(2 + 20800 + 3392);
    check_eq("coll_new", {23'd0, r1, g1, b1}, 32'o333);

    // one-CLK reset in the middle of a line
    NRST = 1'b0;
    go_to(ncyc + 1);
    check_eq("mrst_de", 32'(de1), 32'd0);
    check_eq("mrst_rgb", {23'd0, r1, g1, b1}, 32'd0);
    check_eq("mrst_hs", 32'(hs1), 32'd1);
    check_eq("mrst_vs", 32'(vs1), 32'd1);
    check_eq("mrst_fs", 32'(fs1), 32'd0);
    check_eq("mrst_de2", 32'(de2), 32'd0);
    NRST = 1'b1; ncyc = 0;
    go_to(1); check_eq("mrst_fs_early", 32'(fs1), 32'd0);
    go_to(2); check_eq("mrst_fs_first", 32'(fs1), 32'd1);
    px1("kept_192_4", 192, 4, 9'o333);
    px1("kept_447_9", 447, 9, 9'o005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
